// File: rtl/tc_pkg.sv
// Shared definitions for the TC0/TC1 timer_counter peripheral:
// register offsets, modes, CTRL bit positions and FSM state encoding.
package tc_pkg;

  localparam int TC_CNT_W = 32;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam logic [1:0] TC_ONESHOT = 2'b00;
  localparam logic [1:0] TC_RELOAD  = 2'b01;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;  // two bits, [2:1]
  localparam int CTRL_IM   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counter behind the CPU peripheral bridge: CTRL/PRESET/COUNT
// register window, one-shot or auto-reload modes, masked registered IRQ.
//
// state | meaning
// IDLE  | stopped; waits for CTRL.En
// LOAD  | COUNT <= PRESET
// CNT   | decrementing toward zero
// INT   | terminal count reached; one-shot clears En, reload restarts
module timer_counter
  import tc_pkg::*;
#(
  parameter int CNT_W = TC_CNT_W
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_addr,
  input  logic        i_we,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out,
  output logic        o_irq
);

  logic             r_en;
  logic [1:0]       r_mode;
  logic             r_im;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  tc_state_e        r_state;
  logic             r_irq_pend;
  logic             r_irq;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_en_eff;
  logic w_reload;

  assign w_wr_ctrl   = i_we && (i_addr == TC_CTRL);
  assign w_wr_preset = i_we && (i_addr == TC_PRESET);
  // A software stop takes effect on the write edge itself while running.
  assign w_en_eff    = w_wr_ctrl ? i_data_in[CTRL_EN] : r_en;
  assign w_reload    = (r_mode == TC_RELOAD);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_en       <= 1'b0;
      r_mode     <= TC_ONESHOT;
      r_im       <= 1'b0;
      r_preset   <= '0;
      r_count    <= '0;
      r_state    <= IDLE;
      r_irq_pend <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= r_im & r_irq_pend;
      if (w_wr_ctrl) begin
        r_en   <= i_data_in[CTRL_EN];
        r_mode <= i_data_in[CTRL_MODE +: 2];
        r_im   <= i_data_in[CTRL_IM];
      end
      if (w_wr_preset)
        r_preset <= i_data_in[CNT_W-1:0];
      if (w_wr_ctrl || w_wr_preset)
        r_irq_pend <= 1'b0;

      case (r_state)
        IDLE: if (r_en) r_state <= LOAD;
        LOAD: begin
          r_count <= r_preset;
          r_state <= CNT;
        end
        CNT: begin
          if (!w_en_eff) begin
            r_state <= IDLE;
          end else if (r_count > CNT_W'(1)) begin
            r_count <= r_count - CNT_W'(1);
          end else begin
            r_count    <= '0;
            r_irq_pend <= 1'b1;
            r_state    <= INT;
          end
        end
        INT: begin
          if (w_reload) begin
            r_irq_pend <= 1'b0;
            r_state    <= w_en_eff ? LOAD : IDLE;
          end else begin
            // a same-cycle CTRL write overrides the hardware En clear
            if (!w_wr_ctrl) r_en <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_data_out = '0;
    case (i_addr)
      TC_CTRL: begin
        o_data_out[CTRL_EN]         = r_en;
        o_data_out[CTRL_MODE +: 2]  = r_mode;
        o_data_out[CTRL_IM]         = r_im;
      end
      TC_PRESET: o_data_out = 32'(r_preset);
      TC_COUNT:  o_data_out = 32'(r_count);
      default:   o_data_out = '0;
    endcase
  end

  assign o_irq = r_irq;

endmodule

// File: tb/tb_timer_counter.sv
// Directed vector bench for timer_counter: one table row per clock edge,
// plus a hand-written reload-period measurement.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [1:0]  i_addr = 2'd0;
  logic        i_we = 1'b0;
  logic [31:0] i_data_in = '0;
  logic [31:0] o_data_out;
  logic        o_irq;

  int checks = 0;
  int errors = 0;

  timer_counter dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_addr     (i_addr),
    .i_we       (i_we),
    .i_data_in  (i_data_in),
    .o_data_out (o_data_out),
    .o_irq      (o_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic rst, logic we, logic [1:0] wa, logic [31:0] wd,
                             logic [1:0] ra, logic [31:0] er, logic ei);
    vec_t t;
    t.rst = rst; t.we = we; t.waddr = wa; t.wdata = wd;
    t.raddr = ra; t.exp_rd = er; t.exp_irq = ei;
    return t;
  endfunction

  // idle edge: no write, then read back
  function automatic vec_t n(logic [1:0] ra, logic [31:0] er, logic ei);
    return v(1'b0, 1'b0, 2'd0, 32'd0, ra, er, ei);
  endfunction

  // write edge, then read back
  function automatic vec_t w(logic [1:0] wa, logic [31:0] wd, logic [1:0] ra,
                             logic [31:0] er, logic ei);
    return v(1'b0, 1'b1, wa, wd, ra, er, ei);
  endfunction

  localparam logic [1:0] A_CTRL = 2'd0, A_PRE = 2'd1, A_CNT = 2'd2, A_UNU = 2'd3;

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    i_we = 1'b1; i_addr = a; i_data_in = d;
    @(posedge clk);
    #1;
    i_we = 1'b0;
  endtask

  initial begin
    int t1, t2;

    // one-shot, PRESET=5, IM=1
    vq.push_back(v(1'b1, 1'b0, 2'd0, 32'd0, A_CTRL, 32'h0, 1'b0));
    vq.push_back(w(A_PRE,  32'd5,   A_PRE,  32'd5, 1'b0));
    vq.push_back(w(A_CTRL, 32'h9,   A_CNT,  32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd5, 1'b0));
    vq.push_back(n(A_CNT, 32'd4, 1'b0));
    vq.push_back(n(A_CNT, 32'd3, 1'b0));
    vq.push_back(n(A_CNT, 32'd2, 1'b0));
    vq.push_back(n(A_CNT, 32'd1, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CTRL, 32'h8, 1'b1));
    vq.push_back(n(A_CNT, 32'd0, 1'b1));
    vq.push_back(n(A_CTRL, 32'h8, 1'b1));
    // PRESET write clears the pending interrupt
    vq.push_back(w(A_PRE, 32'd3, A_PRE, 32'd3, 1'b1));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    // auto-reload, PRESET=2: 4-cycle period, one-cycle IRQ pulse
    vq.push_back(w(A_PRE,  32'd2, A_PRE, 32'd2, 1'b0));
    vq.push_back(w(A_CTRL, 32'hB, A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd2, 1'b0));
    vq.push_back(n(A_CNT, 32'd1, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b1));
    vq.push_back(n(A_CNT, 32'd2, 1'b0));
    vq.push_back(n(A_CNT, 32'd1, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b1));
    vq.push_back(n(A_CNT, 32'd2, 1'b0));
    vq.push_back(n(A_CNT, 32'd1, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    // En=0 written during INT in reload mode -> IDLE, no reload
    vq.push_back(w(A_CTRL, 32'hA, A_CTRL, 32'hA, 1'b1));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    // one-shot with IM=0: no IRQ; CTRL=0x8 clears pending
    vq.push_back(w(A_PRE,  32'd10, A_PRE,  32'd10, 1'b0));
    vq.push_back(w(A_CTRL, 32'h1,  A_CTRL, 32'h1,  1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd10, 1'b0));
    for (int k = 9; k >= 1; k--) vq.push_back(n(A_CNT, 32'(k), 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CTRL, 32'h0, 1'b0));
    vq.push_back(n(A_CTRL, 32'h0, 1'b0));
    vq.push_back(w(A_CTRL, 32'h8, A_CTRL, 32'h8, 1'b0));
    vq.push_back(n(A_CTRL, 32'h8, 1'b0));
    // pause mid-count, reload on re-enable, read-only COUNT, PRESET during CNT
    vq.push_back(w(A_PRE,  32'd8, A_PRE,  32'd8, 1'b0));
    vq.push_back(w(A_CTRL, 32'h1, A_CTRL, 32'h1, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd8, 1'b0));
    vq.push_back(n(A_CNT, 32'd7, 1'b0));
    vq.push_back(n(A_CNT, 32'd6, 1'b0));
    vq.push_back(w(A_CTRL, 32'h0, A_CNT, 32'd6, 1'b0));
    vq.push_back(n(A_CNT, 32'd6, 1'b0));
    vq.push_back(w(A_PRE,  32'd9, A_CNT, 32'd6, 1'b0));
    vq.push_back(w(A_CTRL, 32'h1, A_CNT, 32'd6, 1'b0));
    vq.push_back(n(A_CNT, 32'd6, 1'b0));
    vq.push_back(n(A_CNT, 32'd9, 1'b0));
    vq.push_back(w(A_CNT, 32'h1234, A_CNT, 32'd8, 1'b0));
    vq.push_back(w(A_PRE, 32'd3,    A_CNT, 32'd7, 1'b0));
    vq.push_back(w(A_UNU, 32'hFFFF_FFFF, A_UNU, 32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd5, 1'b0));
    // switch to reload at COUNT=4, then reset with a same-cycle CTRL write
    vq.push_back(w(A_CTRL, 32'hB, A_CNT, 32'd4, 1'b0));
    vq.push_back(v(1'b1, 1'b1, A_CTRL, 32'hF, A_CTRL, 32'h0, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_PRE, 32'd0, 1'b0));
    vq.push_back(n(A_UNU, 32'd0, 1'b0));
    // software re-arm on the same edge as the one-shot En clear
    vq.push_back(w(A_PRE,  32'd1, A_PRE,  32'd1, 1'b0));
    vq.push_back(w(A_CTRL, 32'h9, A_CTRL, 32'h9, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CNT, 32'd1, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(w(A_CTRL, 32'h9, A_CTRL, 32'h9, 1'b1));
    vq.push_back(n(A_CTRL, 32'h9, 1'b0));
    vq.push_back(n(A_CNT, 32'd1, 1'b0));
    vq.push_back(n(A_CNT, 32'd0, 1'b0));
    vq.push_back(n(A_CTRL, 32'h8, 1'b1));
    vq.push_back(v(1'b1, 1'b0, 2'd0, 32'd0, A_CTRL, 32'h0, 1'b0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      i_reset = vq[i].rst; i_we = vq[i].we;
      i_addr = vq[i].waddr; i_data_in = vq[i].wdata;
      @(posedge clk);
      #1;
      i_reset = 1'b0; i_we = 1'b0; i_addr = vq[i].raddr;
      #1;
      checks++;
      if (o_data_out !== vq[i].exp_rd) begin
        errors++;
        $display("FAIL vec%0d rd[%0d]: got %h expected %h", i, vq[i].raddr, o_data_out, vq[i].exp_rd);
      end
      checks++;
      if (o_irq !== vq[i].exp_irq) begin
        errors++;
        $display("FAIL vec%0d irq: got %b expected %b", i, o_irq, vq[i].exp_irq);
      end
    end

    // reload with PRESET=0 behaves as PRESET=1: IRQ period of 3 cycles
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'hB);
    t1 = -1; t2 = -1;
    for (int c = 0; c < 40 && t2 < 0; c++) begin
      @(posedge clk);
      #1;
      if (o_irq) begin
        if (t1 < 0) t1 = c;
        else t2 = c;
      end
    end
    checks++;
    if (t1 < 0 || t2 < 0) begin
      errors++;
      $display("FAIL preset0_period: timeout waiting for IRQ pulses (t1=%0d t2=%0d)", t1, t2);
    end else if (t2 - t1 != 3) begin
      errors++;
      $display("FAIL preset0_period: got %0d cycles expected 3", t2 - t1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
